// File: rtl/gato_turn_seq.sv
// rtl/gato_turn_seq.sv - turn sequencer for an N-player board game
// Hands the turn between players, requests status checks and records the game result.
module gato_turn_seq #(
  parameter int N_PLAYERS   = 2,
  parameter int MAX_MOVES   = 9,
  parameter int TIMEOUT_CYC = 0,
  localparam int PW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1,
  localparam int CW = $clog2(MAX_MOVES + 1),
  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [N_PLAYERS-1:0] mm,
  input  logic                 st_valid,
  input  logic                 st_win,
  input  logic                 st_tie,
  output logic [N_PLAYERS-1:0] turno,
  output logic [PW-1:0]        cur_player,
  output logic                 verifica_status,
  output logic                 win_game,
  output logic                 tie_game,
  output logic                 timeout_game,
  output logic [PW-1:0]        winner,
  output logic [CW-1:0]        move_count,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MOVE    = 3'd1,
    S_CHECK   = 3'd2,
    S_RELEASE = 3'd3,
    S_WIN     = 3'd4,
    S_TIE     = 3'd5,
    S_TOUT    = 3'd6
  } state_t;

  localparam bit          TO_EN   = (TIMEOUT_CYC > 0);
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [PW-1:0] LAST_P  = PW'(N_PLAYERS - 1);
  localparam logic [CW-1:0] MAX_MC  = CW'(MAX_MOVES);

  state_t        state_q, state_d;
  logic [TW-1:0] timer;
  logic          move_hit, to_hit, tie_hit;

  assign move_hit = mm[cur_player];
  assign to_hit   = TO_EN && (timer == TO_LAST);
  assign tie_hit  = st_tie || (move_count == MAX_MC);
  assign state    = state_q;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // A move in the same cycle as timeout expiry wins over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_MOVE;
      S_MOVE: begin
        if (move_hit)    state_d = S_CHECK;
        else if (to_hit) state_d = S_TOUT;
      end
      S_CHECK: begin
        if (st_valid) begin
          if (st_win)       state_d = S_WIN;
          else if (tie_hit) state_d = S_TIE;
          else              state_d = S_RELEASE;
        end
      end
      S_RELEASE: if (!move_hit) state_d = S_MOVE;
      S_WIN, S_TIE, S_TOUT: if (start) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    turno           = '0;
    verifica_status = 1'b0;
    if (state_q == S_MOVE)  turno[cur_player] = 1'b1;
    if (state_q == S_CHECK) verifica_status   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_player   <= '0;
      move_count   <= '0;
      timer        <= '0;
      winner       <= '0;
      win_game     <= 1'b0;
      tie_game     <= 1'b0;
      timeout_game <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cur_player   <= '0;
            move_count   <= '0;
            timer        <= '0;
            winner       <= '0;
            win_game     <= 1'b0;
            tie_game     <= 1'b0;
            timeout_game <= 1'b0;
          end
        end
        S_MOVE: begin
          timer <= timer + TW'(1);
          if (move_hit) begin
            move_count <= move_count + CW'(1);
          end else if (to_hit) begin
            timeout_game <= 1'b1;
            winner       <= cur_player;
          end
        end
        S_CHECK: begin
          if (st_valid) begin
            if (st_win) begin
              win_game <= 1'b1;
              winner   <= cur_player;
            end else if (tie_hit) begin
              tie_game <= 1'b1;
            end
          end
        end
        S_RELEASE: begin
          if (!move_hit) begin
            cur_player <= (cur_player == LAST_P) ? '0 : cur_player + PW'(1);
            timer      <= '0;
          end
        end
        S_WIN, S_TIE, S_TOUT: begin
          if (start) begin
            win_game     <= 1'b0;
            tie_game     <= 1'b0;
            timeout_game <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
